gcd_rr_scheduler: RTL
=====================

// Module: gcd_rr_scheduler
// PURPOSE
//   Shares one iterative subtractive GCD engine among N_REQ requesters.
//   A round-robin arbiter grants one job at a time and latches that job's operands.
//   The engine runs one subtract step per cycle. The result is returned through a
//   valid/ready response port tagged with the requester id.
//   Sits between operand producers and the GCD datapath; replaces per-client GCD instances.
// PARAMETERS
//   N_REQ  4  number of requesters (>=2)
//   W      6  operand/result width
//   IDW    2  requester id width, = clog2(N_REQ)
// PORTS
//   clk        in   1        single clock, all state on posedge
//   rst        in   1        synchronous, active-high reset
//   req        in   N_REQ    per-requester request; held with operands until gnt
//   ain        in   N_REQ*W  operand A, requester i at [i*W +: W]
//   bin        in   N_REQ*W  operand B, same packing
//   gnt        out  N_REQ    one-hot, registered, one-cycle accept pulse
//   rsp_valid  out  1        result available; held until rsp_ready
//   rsp_ready  in   1        consumer accepts result
//   rsp_id     out  IDW      requester index of result
//   rsp_out    out  W        gcd(A,B)
//   rsp_err    out  1        both operands were zero (rsp_out=0)
//   rsp_iters  out  W        subtract steps taken for this job
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_out=0,
//     rsp_err=0, rsp_iters=0, busy=0. Reset mid-job discards the job silently.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE, req!=0 at edge: winner = first set bit of req searching rr_ptr, rr_ptr+1,
//     ... mod N_REQ. In the same edge: latch A,B,id; iters=0;
//     gnt<=onehot(winner); rr_ptr<=(winner+1) mod N_REQ; state<=RUN.
//     gnt is high exactly the one cycle after the decision edge.
//   RUN, per edge, in priority order:
//     A==0 | B==0 -> out=A|B, err=(A==0&B==0), DONE
//     A==B        -> out=A, err=0, DONE
//     A>B         -> A<=A-B, iters++
//     A<B         -> B<=B-A, iters++
//   Result regs and rsp_valid are loaded on the RUN->DONE edge.
//   DONE: rsp_valid=1 with rsp_* stable. On the edge with rsp_valid&rsp_ready:
//     rsp_valid<=0, state<=IDLE.
//   rsp_ready high in the first DONE cycle: zero stall; next grant is decided on
//     the following IDLE edge.
//   Latency: gnt in cycle c; rsp_valid first high in cycle c+1+nsub.
//     nsub = subtract steps; nsub=0 for equal or zero operands.
//   Worst case nsub = 2^W-2 (e.g. 63,1 gives 62). iters never wraps. No timeout needed.
//   req seen during RUN/DONE is ignored, not queued. Requester drops req on the edge
//     after it sees gnt; the minimum 2-cycle RUN+DONE guarantees no double grant.
//   Arithmetic is unsigned W-bit; subtraction never underflows by construction.
// STRUCTURE
//   gcd_pkg: state encoding localparams (S_IDLE, S_RUN, S_DONE) and default W.
//   Sub-module gcd_sub_engine: load/step/done with A,B regs, compare and subtract.
//     The scheduler owns the arbiter, FSM, rr_ptr and response regs.
// TESTING
//   1 Single req[0], A=12, B=18 -> gnt=0001 one cycle; 2 steps; rsp_out=6, id=0,
//     iters=2, err=0, rsp_valid in cycle gnt+3.
//   2 req=1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0; each rsp_id matches
//     its grant.
//   3 A=0,B=5 -> rsp_out=5, err=0. A=0,B=0 -> rsp_out=0, err=1. A=9,B=9 -> out=9,
//     iters=0. All valid in cycle gnt+1.
//   4 A=63, B=1 -> iters=62, rsp_out=1, no wrap; busy high for the whole job.
//   5 rsp_ready=0 for 10 cycles in DONE -> rsp_* held stable, no new gnt; ready=1
//     -> release, next grant follows.
//   6 rst pulse during RUN -> next cycle all outputs 0, no response issued,
//     rr_ptr=0 (req=1010 then grants 1).

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the round-robin GCD scheduler.
package gcd_pkg;
    localparam int DEF_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/gcd_sub_engine.sv
// Iterative subtractive GCD datapath: load operands, then one subtract step per enabled cycle.
module gcd_sub_engine
    import gcd_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic         o_err,
    output logic [W-1:0] o_iters
);
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_iters;
    logic         w_zero;

    assign w_zero   = (r_a == '0) || (r_b == '0);
    assign o_done   = w_zero || (r_a == r_b);
    assign o_result = w_zero ? (r_a | r_b) : r_a;
    assign o_err    = (r_a == '0) && (r_b == '0);
    assign o_iters  = r_iters;

    // Only the larger operand shrinks, so the subtraction can never underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_iters <= '0;
        end else if (i_load) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_iters <= '0;
        end else if (i_step && !o_done) begin
            if (r_a > r_b) r_a <= r_a - r_b;
            else           r_b <= r_b - r_a;
            r_iters <= r_iters + 1'b1;
        end
    end
endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin arbiter and job FSM sharing one GCD engine among N_REQ requesters.
module gcd_rr_scheduler
    import gcd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = DEF_W,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] ain,
    input  logic [N_REQ*W-1:0] bin,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_out,
    output logic               rsp_err,
    output logic [W-1:0]       rsp_iters,
    output logic               busy
);
    state_t             r_state;
    state_t             w_next;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_job_id;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [W-1:0]       r_rsp_out;
    logic               r_rsp_err;
    logic [W-1:0]       r_rsp_iters;

    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_ptr_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_eng_done;
    logic [W-1:0]       w_eng_result;
    logic               w_eng_err;
    logic [W-1:0]       w_eng_iters;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_ptr_nxt = IDW'((int'(w_win) + 1) % N_REQ);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_eng_done) w_next = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_job_id    <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_out   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_iters <= '0;
        end else begin
            r_state <= w_next;
            r_gnt   <= '0;
            if (w_load) begin
                r_gnt    <= N_REQ'(1) << w_win;
                r_rr_ptr <= w_ptr_nxt;
                r_job_id <= w_win;
            end
            if (r_state == S_RUN && w_eng_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_job_id;
                r_rsp_out   <= w_eng_result;
                r_rsp_err   <= w_eng_err;
                r_rsp_iters <= w_eng_iters;
            end
            if (r_state == S_DONE && rsp_ready) r_rsp_valid <= 1'b0;
        end
    end

    gcd_sub_engine #(.W(W)) u_engine (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_a      (ain[int'(w_win)*W +: W]),
        .i_b      (bin[int'(w_win)*W +: W]),
        .o_done   (w_eng_done),
        .o_result (w_eng_result),
        .o_err    (w_eng_err),
        .o_iters  (w_eng_iters)
    );

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_out   = r_rsp_out;
    assign rsp_err   = r_rsp_err;
    assign rsp_iters = r_rsp_iters;
    assign busy      = (r_state != S_IDLE);
endmodule
